// File: rtl/ram_pkg.sv
// Shared word/address types and default geometry for the FIR sample delay-line RAM.
package ram_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/ram_16x256.sv
// Simple dual-port sync RAM (1 write, 1 read, one clock); read latency 1, or 2 with OUT_REG.
// No backpressure: a write is taken on every wren edge and a read issued on every clock.
module ram_16x256 #(
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
    parameter int OUT_REG    = 0
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);
    import ram_pkg::*;

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    // Declaration initialiser becomes the RAM power-up image; the array itself stays reset-free.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
    end

    // Read and write share the edge, so a same-address read returns the old word.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rdaddress];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;

            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_q;
                end
            end

            assign q = out_q;
        end else begin : g_no_out_reg
            assign q = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_16x256.sv
// Randomised and directed bench for ram_16x256 with a scoreboard queue and a plain-array memory model.
module tb_ram_16x256;
    import ram_pkg::*;

    localparam int OUT_REG = 0;
    localparam int LAT     = OUT_REG + 1;

    typedef struct {
        int    due;
        word_t exp;
        string tag;
    } sb_entry_t;

    logic  clock = 1'b0;
    logic  aclr  = 1'b1;
    word_t data  = '0;
    addr_t wraddress = '0;
    logic  wren  = 1'b0;
    addr_t rdaddress = '0;
    word_t q;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    word_t     ref_mem [DEPTH];
    sb_entry_t sb_q [$];

    ram_16x256 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUT_REG    (OUT_REG)
    ) dut (
        .clock     (clock),
        .aclr      (aclr),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .q         (q)
    );

    always #5 clock = ~clock;

    // Monitor: the read word for a request issued before edge k is due just after edge k+LAT-1.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            edge_cnt++;
            while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
                sb_entry_t e;
                e = sb_q.pop_front();
                checks++;
                if (q !== e.exp) begin
                    errors++;
                    $display("FAIL %s: q=%h expected=%h (edge %0d)", e.tag, q, e.exp, edge_cnt);
                end
            end
        end
    end

    task automatic direct_check(input string tag, input word_t exp);
        checks++;
        if (q !== exp) begin
            errors++;
            $display("FAIL %s: q=%h expected=%h", tag, q, exp);
        end
    endtask

    // Drive one clock's worth of inputs (called just after a falling edge) and update the model.
    task automatic step(input logic we, input addr_t wa, input word_t d,
                        input addr_t ra, input bit chk, input string tag);
        sb_entry_t e;
        wren      = we;
        wraddress = wa;
        data      = d;
        rdaddress = ra;
        if (chk) begin
            e.due = edge_cnt + LAT;
            e.exp = ref_mem[ra];
            e.tag = tag;
            sb_q.push_back(e);
        end
        if (we) ref_mem[wa] = d;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, "idle");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d expected=0", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        #1;
        direct_check("reset_q_zero", '0);
        @(negedge clock);
        @(negedge clock);
        aclr = 1'b0;

        // Power-up image: every word reads 0.
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, addr_t'(a), 1'b1, "powerup_zero");

        // Write disabled must not touch memory.
        step(1'b0, 8'd7, 16'hFFFF, 8'd0, 1'b0, "wr_dis");
        step(1'b0, '0, '0, 8'd7, 1'b1, "wren0_addr7");

        // Basic write then back-to-back reads, including top address.
        step(1'b1, 8'd5,   16'h1234, 8'd0, 1'b0, "wr5");
        step(1'b1, 8'd255, 16'hBEEF, 8'd0, 1'b0, "wr255");
        step(1'b0, '0, '0, 8'd5,   1'b1, "rd5");
        step(1'b0, '0, '0, 8'd255, 1'b1, "rd255");

        // Read-during-write at the same address returns the old word.
        step(1'b1, 8'd10, 16'h00AA, 8'd0,  1'b0, "preload10");
        step(1'b1, 8'd10, 16'h0055, 8'd10, 1'b1, "rdw_old");
        step(1'b0, '0, '0, 8'd10, 1'b1, "rdw_new");

        // Asynchronous clear of the read path; memory survives and accepts writes under clear.
        for (int a = 0; a < 4; a++) step(1'b1, addr_t'(a), word_t'(a + 1), 8'd0, 1'b0, "fill");
        step(1'b0, '0, '0, 8'd3, 1'b1, "pre_clr");
        step(1'b0, '0, '0, 8'd3, 1'b0, "hold3");
        idle(LAT);
        #2;
        aclr = 1'b1;
        #1;
        direct_check("aclr_async", '0);
        @(negedge clock);
        step(1'b1, 8'd20, 16'h5A5A, 8'd3, 1'b0, "wr_under_clr");
        direct_check("aclr_hold", '0);
        aclr = 1'b0;
        for (int a = 0; a < 4; a++) step(1'b0, '0, '0, addr_t'(a), 1'b1, "post_clr_keep");
        step(1'b0, '0, '0, 8'd20, 1'b1, "wr_during_clr");

        // Streaming delay line of depth 199 across the address wrap.
        for (int n = 0; n < 512; n++) begin
            step(1'b1, addr_t'(n % 256), word_t'(n), addr_t'((n - 199) & 255),
                 n >= 199, "delay_line");
        end

        // Random traffic on a narrow address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 15)),
                 word_t'($urandom), addr_t'($urandom_range(0, 15)), 1'b1, "random");
        end

        // Bounded drain of outstanding scoreboard entries.
        for (int i = 0; i < LAT + 4 && sb_q.size() > 0; i++) @(negedge clock);
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
